// File: rtl/polarity_pkg.sv
// rtl/polarity_pkg.sv - shared types and constants for the polarity-correcting serial receiver
//
// Purpose : state encoding, default sync word / widths, and a helper that
//           serialises a word MSB-first (bit index 0 is the first bit on the line).
// Ports   : none (package)
package polarity_pkg;

  typedef enum logic {
    HUNT = 1'b0,
    DATA = 1'b1
  } state_t;

  localparam int                    SYNC_W_DEF = 8;
  localparam logic [SYNC_W_DEF-1:0] SYNC_DEF   = 8'hA5;
  localparam int                    DATA_W_DEF = 8;

  // Returns the idx-th bit of word in transmit order (idx 0 = MSB).
  function automatic logic ser_bit(input logic [DATA_W_DEF-1:0] word, input int idx);
    logic [DATA_W_DEF-1:0] v;
    v = word << idx;
    return v[DATA_W_DEF-1];
  endfunction

endpackage

// File: rtl/polarity_sync_det.sv
// rtl/polarity_sync_det.sv - sync-word shift register with true/inverted match detection
//
// Purpose : keeps the last SYNC_W-1 line bits plus a saturating fill count, and
//           flags, combinationally, when the bit arriving this cycle completes a
//           SYNC_W-bit window equal to SYNC (true) or ~SYNC (inverted).
// Ports   : clk, rst         - clock, synchronous active-high reset
//           i_din, i_din_valid - serial line bit and its qualifier
//           i_fill_clr       - zero the fill count (entry to HUNT)
//           o_match_true     - window after this bit equals SYNC
//           o_match_inv      - window after this bit equals ~SYNC
module polarity_sync_det
  import polarity_pkg::*;
#(
  parameter int                SYNC_W = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC   = SYNC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic i_din,
  input  logic i_din_valid,
  input  logic i_fill_clr,
  output logic o_match_true,
  output logic o_match_inv
);

  localparam int FW = $clog2(SYNC_W + 1);

  // Only SYNC_W-1 history bits are stored; the incoming bit completes the window.
  logic [SYNC_W-2:0] r_sr;
  logic [FW-1:0]     r_fill;
  logic [SYNC_W-1:0] w_sr_next;
  logic [FW-1:0]     w_fill_next;
  logic              w_full;

  always_comb begin
    w_sr_next    = {r_sr, i_din};
    w_fill_next  = (r_fill == FW'(SYNC_W)) ? r_fill : r_fill + 1'b1;
    w_full       = i_din_valid && (w_fill_next == FW'(SYNC_W));
    o_match_true = w_full && (w_sr_next == SYNC);
    o_match_inv  = w_full && (w_sr_next == ~SYNC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sr   <= '0;
      r_fill <= '0;
    end else begin
      if (i_din_valid) begin
        r_sr <= w_sr_next[SYNC_W-2:0];
      end
      if (i_fill_clr) begin
        r_fill <= '0;
      end else if (i_din_valid) begin
        r_fill <= w_fill_next;
      end
    end
  end

endmodule

// File: rtl/polarity_rx.sv
// rtl/polarity_rx.sv - serial receiver that detects line polarity from the sync word
//
// Purpose : hunts for SYNC or ~SYNC, latches line polarity, then deserialises
//           FRAME_WORDS payload words (re-inverted when needed) into a one-entry
//           valid/ready output register. Words completing while the register is
//           full and not being accepted are dropped and flagged in sticky overflow.
// Ports   : clk, rst            - clock, synchronous active-high reset
//           din, din_valid      - serial line bit (MSB first) and qualifier
//           out_data, out_valid, out_ready - corrected word output handshake
//           locked              - 1 while in DATA state
//           inverted            - polarity latched at the last sync
//           overflow            - sticky word-dropped flag
//           inv_syncs, flips    - optional sync statistics (POLARITY_RX_STATS_EN)
// Config  : define POLARITY_RX_STATS_EN to add the inv_syncs / flips counters.
module polarity_rx
  import polarity_pkg::*;
#(
  parameter int                SYNC_W      = SYNC_W_DEF,
  parameter logic [SYNC_W-1:0] SYNC        = SYNC_DEF,
  parameter int                DATA_W      = DATA_W_DEF,
  parameter int                FRAME_WORDS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              din,
  input  logic              din_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              locked,
  output logic              inverted,
`ifdef POLARITY_RX_STATS_EN
  output logic [7:0]        inv_syncs,
  output logic [7:0]        flips,
`endif
  output logic              overflow
);

  localparam int BW = $clog2(DATA_W + 1);
  localparam int WW = $clog2(FRAME_WORDS + 1);

  state_t            r_state;
  state_t            w_state_next;
  logic [BW-1:0]     r_bit_cnt;
  logic [WW-1:0]     r_word_cnt;
  logic [DATA_W-2:0] r_acc;
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_inverted;
  logic              r_overflow;

  logic              w_match_true;
  logic              w_match_inv;
  logic              w_sync_hit;
  logic              w_bit;
  logic [DATA_W-1:0] w_word;
  logic              w_word_done;
  logic              w_frame_done;
  logic              w_out_free;
  logic              w_load;
  logic              w_drop;

  polarity_sync_det #(
    .SYNC_W (SYNC_W),
    .SYNC   (SYNC)
  ) u_sync_det (
    .clk          (clk),
    .rst          (rst),
    .i_din        (din),
    .i_din_valid  (din_valid),
    .i_fill_clr   (w_frame_done),
    .o_match_true (w_match_true),
    .o_match_inv  (w_match_inv)
  );

  // Datapath decode shared by the FSM and the registers.
  always_comb begin
    w_sync_hit   = (r_state == HUNT) && (w_match_true || w_match_inv);
    w_bit        = din ^ r_inverted;
    w_word       = {r_acc, w_bit};
    w_word_done  = (r_state == DATA) && din_valid && (r_bit_cnt == BW'(DATA_W - 1));
    w_frame_done = w_word_done && (r_word_cnt == WW'(FRAME_WORDS - 1));
    // The single output slot is usable if empty or being drained this cycle.
    w_out_free   = !r_out_valid || out_ready;
    w_load       = w_word_done && w_out_free;
    w_drop       = w_word_done && !w_out_free;
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HUNT;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM: next state
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      HUNT:    if (w_sync_hit)   w_state_next = DATA;
      DATA:    if (w_frame_done) w_state_next = HUNT;
      default: w_state_next = HUNT;
    endcase
  end

  // FSM: outputs
  always_comb begin
    locked    = (r_state == DATA);
    inverted  = r_inverted;
    out_data  = r_out_data;
    out_valid = r_out_valid;
    overflow  = r_overflow;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt   <= '0;
      r_word_cnt  <= '0;
      r_acc       <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_inverted  <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_sync_hit) begin
        r_inverted <= w_match_inv;
        r_bit_cnt  <= '0;
        r_word_cnt <= '0;
      end

      if ((r_state == DATA) && din_valid) begin
        r_acc <= w_word[DATA_W-2:0];
        if (w_word_done) begin
          r_bit_cnt  <= '0;
          r_word_cnt <= w_frame_done ? '0 : r_word_cnt + 1'b1;
        end else begin
          r_bit_cnt <= r_bit_cnt + 1'b1;
        end
      end

      // A load in the same cycle as an accept keeps out_valid high with new data.
      if (w_load) begin
        r_out_data  <= w_word;
        r_out_valid <= 1'b1;
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end

      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

`ifdef POLARITY_RX_STATS_EN
  logic [7:0] r_inv_syncs;
  logic [7:0] r_flips;
  logic       r_seen_sync;

  // The first sync after reset has no predecessor, so it never counts as a flip.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inv_syncs <= '0;
      r_flips     <= '0;
      r_seen_sync <= 1'b0;
    end else if (w_sync_hit) begin
      r_seen_sync <= 1'b1;
      if (w_match_inv && (r_inv_syncs != 8'hFF)) begin
        r_inv_syncs <= r_inv_syncs + 8'd1;
      end
      if (r_seen_sync && (w_match_inv != r_inverted) && (r_flips != 8'hFF)) begin
        r_flips <= r_flips + 8'd1;
      end
    end
  end

  assign inv_syncs = r_inv_syncs;
  assign flips     = r_flips;
`endif

endmodule

// File: tb/tb_polarity_rx.sv
// tb/tb_polarity_rx.sv - directed self-checking bench for polarity_rx
module tb_polarity_rx;
  import polarity_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       din;
  logic       din_valid;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       locked;
  logic       inverted;
  logic       overflow;
`ifdef POLARITY_RX_STATS_EN
  logic [7:0] inv_syncs;
  logic [7:0] flips;
`endif

  int         n_checks = 0;
  int         n_fail   = 0;
  bit         use_gaps = 1'b0;
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  polarity_rx dut (
    .clk       (clk),
    .rst       (rst),
    .din       (din),
    .din_valid (din_valid),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .locked    (locked),
    .inverted  (inverted),
`ifdef POLARITY_RX_STATS_EN
    .inv_syncs (inv_syncs),
    .flips     (flips),
`endif
    .overflow  (overflow)
  );

  // Words are accepted at the posedge following a negedge that sees valid && ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got_q.push_back(out_data);
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    din_valid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) begin
      if (use_gaps) begin
        din_valid = 1'b0;
        repeat ($urandom_range(0, 2)) tick();
      end
      din       = ser_bit(b, i);
      din_valid = 1'b1;
      tick();
    end
    din_valid = 1'b0;
  endtask

  // Sends a sync and four payload words; inv=1 sends everything inverted on the line.
  task automatic send_frame(input bit inv, input logic [31:0] words);
    logic [7:0] m;
    m = inv ? 8'hFF : 8'h00;
    send_byte(8'hA5 ^ m);
    for (int i = 0; i < 4; i++) send_byte(words[31-8*i -: 8] ^ m);
  endtask

  task automatic check_words(input string tag, input logic [31:0] exp);
    check_eq({tag, "_count"}, got_q.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("%s_w%0d", tag, i),
               (i < got_q.size()) ? {24'h0, got_q[i]} : 32'hDEAD,
               {24'h0, exp[31-8*i -: 8]});
    end
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    din_valid = 1'b0;
    tick();
    rst = 1'b0;
    got_q.delete();
  endtask

  initial begin
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;

    check_eq("rst_locked",   locked,    0);
    check_eq("rst_inverted", inverted,  0);
    check_eq("rst_valid",    out_valid, 0);
    check_eq("rst_data",     out_data,  0);
    check_eq("rst_overflow", overflow,  0);
`ifdef POLARITY_RX_STATS_EN
    check_eq("rst_inv_syncs", inv_syncs, 0);
    check_eq("rst_flips",     flips,     0);
`endif

    // 1: true-polarity line
    send_byte(8'hA5);
    check_eq("t1_locked",   locked,   1);
    check_eq("t1_inverted", inverted, 0);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
    check_eq("t1_still_locked", locked, 1);
    send_byte(8'h44);
    check_eq("t1_unlock", locked, 0);
    idle(3);
    check_words("t1", 32'h11223344);

    // 2: inverted line
    got_q.delete();
    send_byte(8'h5A);
    check_eq("t2_inverted", inverted, 1);
    check_eq("t2_locked",   locked,   1);
    send_byte(8'hEE); send_byte(8'hDD); send_byte(8'hCC); send_byte(8'hBB);
    idle(3);
    check_words("t2", 32'h11223344);
    check_eq("t2_overflow", overflow, 0);

    // 3: backpressure through a whole frame
    got_q.delete();
    out_ready = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h01);
    check_eq("t3_valid1",    out_valid, 1);
    check_eq("t3_data1",     out_data,  8'h01);
    check_eq("t3_ovf_clear", overflow,  0);
    send_byte(8'h02);
    check_eq("t3_ovf_set",   overflow,  1);
    check_eq("t3_data_hold", out_data,  8'h01);
    send_byte(8'h03); send_byte(8'h04);
    check_eq("t3_data_end",  out_data,  8'h01);
    check_eq("t3_valid_end", out_valid, 1);
    check_eq("t3_unlocked",  locked,    0);
    out_ready = 1'b1;
    tick();
    check_eq("t3_drained",  out_valid,    0);
    check_eq("t3_count",    got_q.size(), 1);
    check_eq("t3_accepted", (got_q.size() > 0) ? {24'h0, got_q[0]} : 32'hDEAD, 8'h01);

    // 4: garbage before the sync word
    do_reset();
    send_byte(8'hFF); check_eq("t4_no_lock_ff", locked, 0);
    send_byte(8'h00); check_eq("t4_no_lock_00", locked, 0);
    send_byte(8'hA4); check_eq("t4_no_lock_a4", locked, 0);
    check_eq("t4_no_words", got_q.size(), 0);
    send_frame(1'b0, 32'h55667788);
    idle(3);
    check_words("t4", 32'h55667788);

    // 5: reset mid-frame with a pending output word
    do_reset();
    out_ready = 1'b0;
    send_byte(8'hA5);
    send_byte(8'h99);
    check_eq("t5_pending", out_valid, 1);
    for (int i = 0; i < 4; i++) begin
      din = i[0]; din_valid = 1'b1; tick();
    end
    din_valid = 1'b0;
    check_eq("t5_locked_pre", locked, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    check_eq("t5_locked",   locked,    0);
    check_eq("t5_inverted", inverted,  0);
    check_eq("t5_valid",    out_valid, 0);
    check_eq("t5_data",     out_data,  0);
    check_eq("t5_overflow", overflow,  0);
    got_q.delete();
    out_ready = 1'b1;
    send_frame(1'b1, 32'h11223344);
    check_eq("t5_inv_after", inverted, 1);
    idle(3);
    check_words("t5", 32'h11223344);

    // 6: polarity sequence with random din_valid gaps
    do_reset();
    use_gaps = 1'b1;
    send_frame(1'b0, 32'h11223344); idle(3); check_words("t6a", 32'h11223344); got_q.delete();
    send_frame(1'b1, 32'h55667788); idle(3); check_words("t6b", 32'h55667788); got_q.delete();
    send_frame(1'b1, 32'h01020304); idle(3); check_words("t6c", 32'h01020304); got_q.delete();
    send_frame(1'b0, 32'h0A0B0C0D); idle(3); check_words("t6d", 32'h0A0B0C0D);
    check_eq("t6_inverted", inverted, 0);
    check_eq("t6_overflow", overflow, 0);
`ifdef POLARITY_RX_STATS_EN
    check_eq("t6_inv_syncs", inv_syncs, 2);
    check_eq("t6_flips",     flips,     2);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
